// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory initiator: access sizes, FSM states and
// the default RAM size.
package dmem_pkg;

  localparam int MEM_BYTES_DEF = 1024;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_if.sv
// Load/store request and response channel between the execute stage (master)
// and the data-memory initiator (slave). Suffixes are relative to dmem_master.
interface dmem_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_signed_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [63:0] resp_rdata_o;
  logic        resp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i,
    output resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i,
    input  resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/dmem_lane_merge.sv
// Combinational lane logic: extract/extend a load from the low bytes of the
// RAM window, and splice sub-D store data into the old window contents.
module dmem_lane_merge
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [63:0] old_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] ext_o,
  output logic [63:0] merge_o
);

  always_comb begin
    ext_o   = old_i;
    merge_o = wdata_i;
    case (size_e'(size_i))
      SZ_B: begin
        ext_o   = {{56{signed_i & old_i[7]}}, old_i[7:0]};
        merge_o = {old_i[63:8], wdata_i[7:0]};
      end
      SZ_H: begin
        ext_o   = {{48{signed_i & old_i[15]}}, old_i[15:0]};
        merge_o = {old_i[63:16], wdata_i[15:0]};
      end
      SZ_W: begin
        ext_o   = {{32{signed_i & old_i[31]}}, old_i[31:0]};
        merge_o = {old_i[63:32], wdata_i[31:0]};
      end
      default: begin
        ext_o   = old_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_master.sv
// Data-memory initiator: one outstanding load/store, sub-D stores done as
// read-modify-write against a RAM that always writes an 8-byte window.
module dmem_master
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  dmem_if.slave       req,
  output logic        mem_read_en_o,
  output logic        mem_write_en_o,
  output logic        mem_read_instruction_en_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_write_data_o,
  input  logic [63:0] mem_read_data_i,
  input  logic        mem_error_i
);

  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

  state_e      state_q, state_d;
  logic        we_q, we_d, sgn_q, sgn_d, err_q, err_d;
  logic [1:0]  size_q, size_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [63:0] ext, merge;

  dmem_lane_merge u_lane (
    .size_i   (size_q),
    .signed_i (sgn_q),
    .old_i    (mem_read_data_i),
    .wdata_i  (wdata_q),
    .ext_o    (ext),
    .merge_o  (merge)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      sgn_q   <= sgn_d;
      err_q   <= err_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // The store word register is reused to hold the merged window between RD and WR.
  always_comb begin
    state_d          = state_q;
    we_d             = we_q;
    sgn_d            = sgn_q;
    err_d            = err_q;
    size_d           = size_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    rdata_d          = rdata_q;
    req.req_ready_o  = 1'b0;
    mem_read_en_o    = 1'b0;
    mem_write_en_o   = 1'b0;
    mem_addr_o       = '0;
    mem_write_data_o = '0;
    case (state_q)
      IDLE: begin
        req.req_ready_o = 1'b1;
        if (req.req_valid_i) begin
          we_d    = req.req_we_i;
          sgn_d   = req.req_signed_i;
          size_d  = req.req_size_i;
          addr_d  = req.req_addr_i;
          wdata_d = req.req_wdata_i;
          rdata_d = '0;
          err_d   = 1'b0;
          if (req.req_addr_i > LAST_ADDR) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (!req.req_we_i || req.req_size_i != SZ_D) begin
            state_d = RD;
          end else begin
            state_d = WR;
          end
        end
      end
      RD: begin
        mem_read_en_o = 1'b1;
        mem_addr_o    = addr_q;
        if (mem_error_i) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (!we_q) begin
          rdata_d = ext;
          state_d = RESP;
        end else begin
          wdata_d = merge;
          state_d = WR;
        end
      end
      WR: begin
        mem_write_en_o   = 1'b1;
        mem_addr_o       = addr_q;
        mem_write_data_o = wdata_q;
        if (mem_error_i) err_d = 1'b1;
        state_d = RESP;
      end
      default: begin
        if (req.resp_ready_i) state_d = IDLE;
      end
    endcase
  end

  assign req.resp_valid_o      = (state_q == RESP);
  assign req.resp_rdata_o      = rdata_q;
  assign req.resp_err_o        = err_q;
  assign mem_read_instruction_en_o = 1'b0;

endmodule

// File: tb/tb_dmem_master.sv
// Randomized bench for dmem_master: a byte-array RAM stub answers the bus, and a
// separate byte-level reference memory predicts every response.
module tb_dmem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fill = 1'b1;
  logic        err_inj = 1'b0;
  logic        mem_read_en, mem_write_en, mem_ri_en, mem_error;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  ram     [1024];
  logic [7:0]  ref_mem [1024];
  int          n_chk = 0, n_pass = 0, wr_cnt = 0;

  dmem_if bus();

  dmem_master #(.MEM_BYTES(1024)) dut (
    .clk_i                     (clk),
    .rst_i                     (rst),
    .req                       (bus.slave),
    .mem_read_en_o             (mem_read_en),
    .mem_write_en_o            (mem_write_en),
    .mem_read_instruction_en_o (mem_ri_en),
    .mem_addr_o                (mem_addr),
    .mem_write_data_o          (mem_wdata),
    .mem_read_data_i           (mem_rdata),
    .mem_error_i               (mem_error)
  );

  always #5 clk = ~clk;

  // RAM responder stub: combinational 8-byte read, write on rising edge.
  always_comb begin
    mem_rdata = '0;
    if (mem_addr <= 64'd1016)
      for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = ram[mem_addr[9:0] + 10'(i)];
  end
  assign mem_error = err_inj & (mem_read_en | mem_write_en);

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'(i * 7 + 3);
    end else if (mem_write_en && mem_addr <= 64'd1016) begin
      for (int i = 0; i < 8; i++) ram[mem_addr[9:0] + 10'(i)] <= mem_wdata[8*i +: 8];
    end
  end

  always @(negedge clk) if (mem_write_en) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] sz, input logic sg);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++) v |= 64'(ref_mem[a[9:0] + 10'(i)]) << (8 * i);
    if (sg && n < 8 && v[8*n-1]) v |= ~64'd0 << (8 * n);
    return v;
  endfunction

  // Issue one request at the current negedge, check the whole transaction,
  // and return at the negedge after the response handshake.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [63:0] a, input logic [63:0] wd,
                        input int hold, input logic inj, output logic [63:0] got);
    logic legal, seen;
    int exp_lat, exp_rd, exp_wr, lat, rd, wr, addr_bad;
    logic [63:0] exp_data, cap_d;
    logic cap_e;
    legal    = (a <= 64'd1016);
    exp_lat  = !legal ? 1 : inj ? 2 : (we && sz != 2'd3) ? 3 : 2;
    exp_rd   = (legal && (!we || sz != 2'd3)) ? 1 : 0;
    exp_wr   = (legal && we && !inj) ? 1 : 0;
    exp_data = (legal && !we) ? ref_load(a, sz, sg) : 64'd0;
    chk("req_ready_idle", 64'(bus.req_ready_o), 64'd1);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_size_i   = sz;
    bus.req_signed_i = sg;
    bus.req_addr_i   = a;
    bus.req_wdata_i  = wd;
    err_inj          = inj;
    @(posedge clk);
    lat = 0; rd = 0; wr = 0; addr_bad = 0; seen = 1'b0;
    while (lat < 8 && !seen) begin
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      lat++;
      rd += int'(mem_read_en);
      wr += int'(mem_write_en);
      if ((mem_read_en || mem_write_en) && mem_addr != a) addr_bad++;
      if (bus.resp_valid_o) seen = 1'b1;
    end
    chk("resp_timeout", 64'(seen), 64'd1);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("rd_pulses", 64'(rd), 64'(exp_rd));
    chk("wr_pulses", 64'(wr), 64'(exp_wr));
    chk("mem_addr", 64'(addr_bad), 64'd0);
    chk("resp_err", 64'(bus.resp_err_o), 64'(!legal || inj));
    if (!inj) chk("resp_rdata", bus.resp_rdata_o, exp_data);
    got   = bus.resp_rdata_o;
    cap_d = bus.resp_rdata_o;
    cap_e = bus.resp_err_o;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.resp_valid_o), 64'd1);
      chk("bp_rdata", bus.resp_rdata_o, cap_d);
      chk("bp_err", 64'(bus.resp_err_o), 64'(cap_e));
      chk("bp_req_ready", 64'(bus.req_ready_o), 64'd0);
    end
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    err_inj = 1'b0;
    chk("post_valid", 64'(bus.resp_valid_o), 64'd0);
    if (legal && we && !inj)
      for (int i = 0; i < (1 << sz); i++) ref_mem[a[9:0] + 10'(i)] = wd[8*i +: 8];
  endtask

  initial begin
    logic [63:0] got, save;
    logic [1:0]  sz;
    logic        we;
    logic [63:0] a;
    int          r, w0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 7 + 3);
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'd0;
    bus.req_signed_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    bus.resp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("rst_resp_err", 64'(bus.resp_err_o), 64'd0);
    chk("rst_resp_rdata", bus.resp_rdata_o, 64'd0);
    chk("rst_mem_en", {61'd0, mem_read_en, mem_write_en, mem_ri_en}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    fill = 1'b0;
    rst  = 1'b0;
    @(negedge clk);

    // D round trip, then sub-D RMW, then extension
    do_req(1'b1, 2'd3, 1'b0, 64'd16, 64'h1122334455667788, 0, 1'b0, got);
    do_req(1'b0, 2'd3, 1'b0, 64'd16, 64'd0, 0, 1'b0, got);
    chk("tp_d_roundtrip", got, 64'h1122334455667788);
    do_req(1'b1, 2'd0, 1'b0, 64'd19, 64'h00000000000000AB, 0, 1'b0, got);
    do_req(1'b0, 2'd3, 1'b0, 64'd16, 64'd0, 0, 1'b0, got);
    chk("tp_rmw", got, 64'h11223344AB667788);
    do_req(1'b0, 2'd0, 1'b1, 64'd19, 64'd0, 0, 1'b0, got);
    chk("tp_lb_s", got, 64'hFFFFFFFFFFFFFFAB);
    do_req(1'b0, 2'd0, 1'b0, 64'd19, 64'd0, 0, 1'b0, got);
    chk("tp_lb_u", got, 64'h00000000000000AB);
    do_req(1'b0, 2'd1, 1'b1, 64'd18, 64'd0, 0, 1'b0, got);
    chk("tp_lh_s", got, 64'hFFFFFFFFFFFFAB66);

    // Bounds
    do_req(1'b0, 2'd3, 1'b0, 64'd1016, 64'd0, 0, 1'b0, got);
    do_req(1'b0, 2'd2, 1'b0, 64'd1017, 64'd0, 0, 1'b0, got);
    do_req(1'b1, 2'd2, 1'b0, 64'd1020, 64'hDEADBEEF, 0, 1'b0, got);

    // Backpressure, then memory error during the RD of a sub-D store
    do_req(1'b0, 2'd2, 1'b1, 64'd16, 64'd0, 3, 1'b0, got);
    do_req(1'b1, 2'd1, 1'b0, 64'd40, 64'h5A5A, 0, 1'b1, got);
    do_req(1'b0, 2'd3, 1'b0, 64'd40, 64'd0, 0, 1'b0, got);

    // Reset while a W store to 32 sits in RD
    save = ref_load(64'd32, 2'd3, 1'b0);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'd2;
    bus.req_signed_i = 1'b0; bus.req_addr_i = 64'd32; bus.req_wdata_i = 64'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("mid_rst_in_rd", 64'(mem_read_en), 64'd1);
    w0  = wr_cnt;
    rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", 64'(mem_write_en), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_no_resp", 64'(bus.resp_valid_o), 64'd0);
    chk("mid_rst_no_write", 64'(wr_cnt - w0), 64'd0);
    do_req(1'b0, 2'd3, 1'b0, 64'd32, 64'd0, 0, 1'b0, got);
    chk("mid_rst_mem32", got, save);

    // Random traffic
    for (int t = 0; t < 150; t++) begin
      we = 1'($urandom);
      sz = 2'($urandom);
      r  = int'($urandom_range(0, 9));
      if (r == 0)      a = 64'(1006 + $urandom_range(0, 20));
      else if (r == 1) a = {$urandom, $urandom};
      else             a = 64'($urandom_range(0, 1016));
      do_req(we, sz, 1'($urandom), a, {$urandom, $urandom}, int'($urandom_range(0, 2)),
             ($urandom_range(0, 15) == 0) && !(we && sz == 2'd3), got);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_master.md
# dmem_master

Data-memory initiator for the single-cycle/multicycle CPU datapath. It accepts load/store requests from the execute stage over a valid/ready handshake and drives the byte-addressed 1 KiB `ram` responder. Byte, halfword and word stores are performed as read-modify-write, because the RAM always writes an 8-byte window. Results and errors are returned over a valid/ready response channel.

## Interface
- `MEM_BYTES`, 1024: RAM size in bytes. A legal access satisfies addr ≤ MEM_BYTES−8.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset. Asynchronous and active-high.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted on a cycle where both `req_valid_i` and `req_ready_o` are 1.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_size_i` in 2: access size. 0 = B, 1 = H, 2 = W, 3 = D.
- `req_signed_i` in 1: sign-extend the load result. Ignored for D and for stores.
- `req_addr_i` in 64: byte address.
- `req_wdata_i` in 64: store data, right-aligned.
- `resp_valid_o` out 1: response valid.
- `resp_ready_i` in 1: response consumed.
- `resp_rdata_o` out 64: extended load data. 0 for stores.
- `resp_err_o` out 1: address out of range, or `mem_error_i` was seen.
- `mem_read_en_o` out 1: to `ram.read_en`.
- `mem_write_en_o` out 1: to `ram.write_en`.
- `mem_read_instruction_en_o` out 1: tied to 0.
- `mem_addr_o` out 64: to `ram.addr_i`.
- `mem_write_data_o` out 64: to `ram.write_data_i`.
- `mem_read_data_i` in 64: from `ram.read_data_o`, combinational.
- `mem_error_i` in 1: from `ram.dmem_error_o`.

## Operation
- **Byte ordering.**
  - The RAM returns and writes bytes addr..addr+7, little-endian.
  - The requested datum is always in the low bytes of that window.
  - No alignment requirement.
- **States:** IDLE, RD, WR, RESP.
- **IDLE**
  - `req_ready_o` = 1.
  - On accept, latch we, size, signed, addr and wdata.
  - If the address is illegal, go to RESP with err = 1. No memory enable pulses.
  - Else if the request is a load, or a store with size ≠ D, go to RD.
  - Else (D store) go to WR.
- **RD**
  - Drive `mem_read_en_o` = 1 and `mem_addr_o` = addr.
  - Sample `mem_read_data_i` at the end of the cycle.
  - Load: rdata = low 8/16/32/64 bits, sign- or zero-extended, then go to RESP.
  - Sub-D store: merge = {old[63:8·n], wdata[8·n−1:0]}, where n = 1/2/4 bytes, then go to WR.
- **WR**
  - Drive `mem_write_en_o` = 1, `mem_addr_o` = addr, `mem_write_data_o` = wdata (D) or merge.
  - The RAM commits on this cycle's rising edge. Go to RESP.
- **RESP**
  - `resp_valid_o` = 1, with data and err held stable.
  - On `resp_ready_i` = 1, go to IDLE.
  - `req_ready_o` = 0.
- **`mem_error_i` during RD or WR:** set err, suppress the subsequent WR (write enable only in the cycle already under way), and go to RESP.
- **Outside RD/WR:** memory enables are 0 and `mem_addr_o`/`mem_write_data_o` are 0.
- **Reset (any time):**
  - State returns to IDLE and all registers clear.
  - Any in-flight request is dropped with no response.
  - `mem_write_en_o` deasserts immediately (asynchronously).

## Timing
- **Reset values:**
  - `req_ready_o` = 1.
  - `resp_valid_o`, `resp_err_o`, all `mem_*_o` = 0.
  - `resp_rdata_o` = 0.
- **Latency from the accept edge T0 to `resp_valid_o` high:**
  - Load: 2 cycles (RD at T1, RESP at T2).
  - D store: 2 cycles (WR at T1).
  - Sub-D store: 3 cycles (RD, WR, RESP).
  - Illegal address: 1 cycle.
- **Throughput:** one request outstanding. The next accept is possible in the cycle after the response handshake completes. There is no bypass from RESP to accept.
- **Response outputs** are registered and do not change while `resp_valid_o` && !`resp_ready_i`.

## Structure
- **Package `dmem_pkg`:**
  - Size encodings SZ_B/SZ_H/SZ_W/SZ_D.
  - State enum (IDLE, RD, WR, RESP).
  - Default MEM_BYTES.
- **Sub-module `dmem_lane_merge`** (combinational): load extract/extend and store merge from (size, signed, old, wdata).
- **Top:** FSM plus request/response registers.

## Test plan
- **D round trip.** After reset, store D 0x1122334455667788 at address 16, then load D at address 16.
  - Required: rdata = 0x1122334455667788.
  - Required: `mem_write_en_o` high for exactly 1 cycle.
  - Required: each response arrives 2 cycles after accept.
- **Sub-D store read-modify-write.** Store B 0xAB at address 19, then load D at address 16.
  - Required: 0x11223344AB667788.
  - Required: RD then WR, response 3 cycles after accept.
- **Sign/zero extension.** Starting from the previous memory state:
  - Load B signed at 19 → 0xFFFFFFFFFFFFFFAB.
  - Load B unsigned at 19 → 0x00000000000000AB.
  - Load H signed at 18 → 0xFFFFFFFFFFFFAB66.
- **Bounds.**
  - Load at 1016 succeeds with err = 0.
  - Load at 1017 → err = 1 one cycle after accept, no `mem_read_en_o` pulse.
  - Store at 1020 → err = 1, no `mem_write_en_o` pulse.
- **Response backpressure.** Hold `resp_ready_i` = 0 for 3 cycles on a load response.
  - Required: `resp_valid_o`/`rdata` stable for those cycles.
  - Required: `req_ready_o` = 0 throughout.
  - Required: accept again 1 cycle after the handshake.
- **Reset mid-operation.** Assert `rst_i` during the RD of a W store to address 32.
  - Required: `mem_write_en_o` never asserts and memory at address 32 is unchanged.
  - Required: no response, and `req_ready_o` = 1 after reset.
